// File: rtl/se_seq.sv
// -----------------------------------------------------------------------------
// se_seq -- multi-sector erase sequencer
//
// Issues a run of sector-erase commands to the SE command engine: one se_start
// pulse per sector, an automatic address step of 2^SECTOR_LOG2 between
// sectors, and a settle gap of WAIT_CYC cycles after every non-final se_end.
// Reports progress (sectors_done), completion (done), abort and timeout.
//
// Optional feature (compile-time macro):
//   SE_TIMEOUT_EN  -- when defined, WAIT_END gives up after TIMEOUT_CYC cycles
//                     without se_end and finishes the run with err=1.
//                     When undefined, WAIT_END waits forever and err is 0.
//
// Ports:
//   sclk          in   system clock
//   rst           in   asynchronous active-high reset
//   start         in   one-cycle run request (ignored while busy or num=0)
//   start_addr    in   first sector byte address, sampled with start
//   sector_num    in   number of sectors, sampled with start
//   abort         in   abort request (level or pulse)
//   se_end        in   one-cycle "sector erase finished" from the SE engine
//   se_start      out  one-cycle erase command to the SE engine
//   se_addr       out  address of the sector being erased
//   busy          out  high whenever the sequencer is not idle
//   sectors_done  out  completed sectors in the current/last run
//   done          out  one-cycle run-finished pulse
//   aborted       out  qualifies done: run ended by abort
//   err           out  qualifies done: run ended by timeout
// -----------------------------------------------------------------------------
module se_seq #(
    parameter int ADDR_W      = 24,
    parameter int SECTOR_LOG2 = 16,
    parameter int NUM_W       = 8,
    parameter int WAIT_CYC    = 149_999_999,
    parameter int CNT_W       = 28,
    parameter int TIMEOUT_CYC = 200_000_000
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [NUM_W-1:0]  sector_num,
    input  logic              abort,
    input  logic              se_end,
    output logic              se_start,
    output logic [ADDR_W-1:0] se_addr,
    output logic              busy,
    output logic [NUM_W-1:0]  sectors_done,
    output logic              done,
    output logic              aborted,
    output logic              err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_END,
        ST_GAP,
        ST_FIN
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(1) << SECTOR_LOG2;
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(WAIT_CYC - 1);
    localparam logic [NUM_W-1:0]  NUM_ONE   = NUM_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

`ifdef SE_TIMEOUT_EN
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
`else
    // Timeout limit has no consumer in this build.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NUM_W-1:0]  remain_q, remain_d;
    logic [NUM_W-1:0]  done_cnt_q, done_cnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              abort_pend_q, abort_pend_d;
    logic              aborted_q, aborted_d;
    logic              err_q, err_d;
    logic              se_start_q, busy_q, done_q;

    // Next-state logic.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned (which would infer a latch).
        state_d      = state_q;
        addr_d       = addr_q;
        remain_d     = remain_q;
        done_cnt_d   = done_cnt_q;
        cnt_d        = cnt_q;
        abort_pend_d = abort_pend_q;
        aborted_d    = aborted_q;
        err_d        = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start && (sector_num != '0)) begin
                    state_d      = ST_ISSUE;
                    addr_d       = start_addr;
                    remain_d     = sector_num;
                    done_cnt_d   = '0;
                    aborted_d    = 1'b0;
                    err_d        = 1'b0;
                    abort_pend_d = 1'b0;
                end
            end

            ST_ISSUE: begin
                // Counter restarts here so WAIT_END timeout counts from zero.
                cnt_d = '0;
                if (abort) begin
                    state_d   = ST_FIN;
                    aborted_d = 1'b1;
                end else begin
                    state_d = ST_WAIT_END;
                end
            end

            ST_WAIT_END: begin
                // An abort here only takes effect once the erase completes.
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                if (se_end) begin
                    done_cnt_d = done_cnt_q + NUM_ONE;
                    remain_d   = remain_q - NUM_ONE;
                    if ((remain_q == NUM_ONE) || abort_pend_q || abort) begin
                        state_d   = ST_FIN;
                        aborted_d = abort_pend_q | abort;
                    end else begin
                        addr_d  = addr_q + ADDR_STEP;
                        cnt_d   = '0;
                        state_d = ST_GAP;
                    end
                end
`ifdef SE_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    state_d   = ST_FIN;
                    err_d     = 1'b1;
                    aborted_d = abort_pend_q | abort;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
`endif
            end

            ST_GAP: begin
                if (abort) begin
                    state_d   = ST_FIN;
                    aborted_d = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = ST_ISSUE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_FIN: begin
                state_d      = ST_IDLE;
                abort_pend_d = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; the pulse/level outputs are decoded from the next state
    // so that they appear registered in the same cycle as the state itself.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            remain_q     <= '0;
            done_cnt_q   <= '0;
            cnt_q        <= '0;
            abort_pend_q <= 1'b0;
            aborted_q    <= 1'b0;
            err_q        <= 1'b0;
            se_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q      <= state_d;
            addr_q       <= addr_d;
            remain_q     <= remain_d;
            done_cnt_q   <= done_cnt_d;
            cnt_q        <= cnt_d;
            abort_pend_q <= abort_pend_d;
            aborted_q    <= aborted_d;
            err_q        <= err_d;
            se_start_q   <= (state_d == ST_ISSUE);
            busy_q       <= (state_d != ST_IDLE);
            done_q       <= (state_d == ST_FIN);
        end
    end

    assign se_start     = se_start_q;
    assign se_addr      = addr_q;
    assign busy         = busy_q;
    assign sectors_done = done_cnt_q;
    assign done         = done_q;
    assign aborted      = aborted_q;
    assign err          = err_q;

endmodule

// File: doc/se_seq.md
# se_seq

Parametrised multi-sector erase sequencer for the SPI flash controller. On a start request it issues a run of sector-erase commands to the SE command engine, one `se_start` pulse per sector, with an automatic address step between sectors and a programmable settle gap after each `se_end`. The sector count and base address are supplied at run time. The block reports progress, completion, abort and (optionally) timeout. It sits between the key/command front end and the SE command engine.

## Interface
- `ADDR_W`, 24: flash byte-address width.
- `SECTOR_LOG2`, 16: log2 of the sector size in bytes; address step = 2^SECTOR_LOG2.
- `NUM_W`, 8: width of the sector-count input and the progress counter.
- `WAIT_CYC`, 149_999_999: settle gap length in `sclk` cycles after each non-final `se_end`; must be ≥1.
- `CNT_W`, 28: width of the gap/timeout counter; must hold `WAIT_CYC` and `TIMEOUT_CYC`.
- `TIMEOUT_CYC`, 200_000_000: maximum wait for `se_end`; used only with `SE_TIMEOUT_EN`.

Ports:
- `sclk` in 1: system clock.
- `rst` in 1: reset; one clock; asynchronous, active-high.
- `start` in 1: one-cycle start request.
- `start_addr` in ADDR_W: first sector byte address, sampled with `start`.
- `sector_num` in NUM_W: number of sectors, sampled with `start`.
- `abort` in 1: abort request (level or pulse).
- `se_end` in 1: one-cycle "sector erase finished" from the SE engine.
- `se_start` out 1: one-cycle erase command to the SE engine.
- `se_addr` out ADDR_W: address of the current sector; stable from `se_start` until its `se_end`.
- `busy` out 1: high in every state except IDLE.
- `sectors_done` out NUM_W: count of completed sectors in the current/last run.
- `done` out 1: one-cycle run-finished pulse.
- `aborted` out 1: qualifies `done`; run ended by `abort`.
- `err` out 1: qualifies `done`; run ended by timeout. Always 0 without `SE_TIMEOUT_EN`.

## Operation
- FSM states are IDLE, ISSUE, WAIT_END, GAP, FIN.
- **IDLE**:
  - `start`=1 with `sector_num`≠0: latch `start_addr` → `se_addr`, latch `sector_num` → remaining, clear `sectors_done`, `aborted` and `err`; go to ISSUE.
  - `start` with `sector_num`=0 is ignored.
- **ISSUE**: `se_start`=1 for exactly this cycle, then go to WAIT_END.
- **WAIT_END**:
  - On `se_end`, increment `sectors_done` and decrement remaining.
  - If remaining was 1, or an abort is pending: go to FIN.
  - Otherwise: set `se_addr` += 2^SECTOR_LOG2 (modulo 2^ADDR_W, wraps silently), clear the counter, go to GAP.
- **GAP**: count 0..WAIT_CYC-1, then go to ISSUE.
- **FIN**: `done`=1 for one cycle, then go to IDLE.
- Abort behaviour by state:
  - `abort` in ISSUE or GAP goes to FIN next cycle with `aborted`=1. In ISSUE, `se_start` is still driven that cycle and the sector is counted as issued but not done.
  - `abort` in WAIT_END sets an abort-pending flag; the current erase completes and its `se_end` is counted.
  - `abort` in IDLE is ignored.
- `start` while busy is ignored.
- `se_end` outside WAIT_END is ignored.
- `se_end` and `abort` in the same WAIT_END cycle: the sector counts, then FIN with `aborted`=1.
- `aborted`, `err` and `sectors_done` hold their values after FIN until the next accepted `start`.
- Reset in any state returns to IDLE immediately; a flash erase already in progress is not tracked.

## Timing
- Reset values: state IDLE; `se_start`, `busy`, `done`, `aborted`, `err` = 0; `se_addr` = 0; `sectors_done` = 0; counter = 0.
- `start` sampled at edge of cycle S: `busy`=1 and `se_start`=1 in cycle S+1.
- Non-final `se_end` in cycle E: GAP covers E+1..E+WAIT_CYC; next `se_start` in cycle E+WAIT_CYC+1. `se_addr` updates in cycle E+1.
- Final `se_end` in cycle E: `done`=1 in E+1; `busy`=0 from E+2.
- `abort` in GAP/ISSUE in cycle A: `done` in A+1.
- All outputs are registered.

## Configuration
- `SE_TIMEOUT_EN` defined:
  - The counter also runs in WAIT_END. It reaches TIMEOUT_CYC-1 without `se_end` → FIN with `err`=1; `sectors_done` is not incremented.
  - `se_end` on that same cycle wins (no error).
- Not defined: WAIT_END waits indefinitely, `err` is tied to 0, and `TIMEOUT_CYC` is unused.

## Test plan
Bench parameters: SECTOR_LOG2=16, WAIT_CYC=4, TIMEOUT_CYC=20, ADDR_W=24.
- `start` with addr 0x010000, num 3; `se_end` 10 cycles after each `se_start`
  - -> `se_start` addrs 0x010000, 0x020000, 0x030000
  - -> gaps exactly 4 cycles
  - -> `done` one cycle after third `se_end`; `sectors_done`=3, `aborted`=0.
- `start` with num 0 -> no `se_start`, `busy` stays 0. `start` mid-run -> ignored; latched values unchanged.
- `abort` during GAP after sector 1 of 4 -> `done` next cycle, `aborted`=1, `sectors_done`=1, no further `se_start`.
- `abort` during WAIT_END -> FIN waits for `se_end`; `done` at `se_end`+1, `sectors_done` includes that sector.
- Addr 0xFF0000, num 2 -> second `se_addr`=0x000000 (wrap).
- With `SE_TIMEOUT_EN`, withhold `se_end` -> `done` with `err`=1 at `se_start`+21 cycles. Without the macro -> `busy` held; `rst` pulse returns all outputs to reset values asynchronously.
